// File: rtl/washer_ctrl_param_if.sv
// Control/status bundle between the panel logic and the wash-cycle controller.
// Panel pulses flow in; motor drives, indicators and the display count flow out.
interface washer_ctrl_param_if #(
    parameter int unsigned CNT_W = 6
);
    logic             tick;
    logic             add;
    logic             start;
    logic             emergency;
    logic             mode;
    logic             zheng;
    logic             fan;
    logic             ledzheng;
    logic             ledfan;
    logic             ledstop;
    logic             alarm;
    logic [CNT_W-1:0] count;
    logic [2:0]       phase;

    modport master (
        output tick, add, start, emergency, mode,
        input  zheng, fan, ledzheng, ledfan, ledstop, alarm, count, phase
    );

    modport slave (
        input  tick, add, start, emergency, mode,
        output zheng, fan, ledzheng, ledfan, ledstop, alarm, count, phase
    );
endinterface

// File: rtl/washer_ctrl_param.sv
// Parametrised wash-cycle controller: timed forward/pause/reverse/pause
// motor cycle with forward-only mode, emergency hold/resume and end alarm.
module washer_ctrl_param #(
    parameter int unsigned CNT_W    = 6,
    parameter int unsigned MAX_TIME = 60,
    parameter int unsigned ADD_STEP = 1,
    parameter int unsigned FWD_T    = 20,
    parameter int unsigned REV_T    = 20,
    parameter int unsigned PAUSE_T  = 10,
    parameter int unsigned ALARM_T  = 5
) (
    input  logic clk,
    input  logic rst,
    washer_ctrl_param_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FWD  = 3'd1,
        P1   = 3'd2,
        REV  = 3'd3,
        P2   = 3'd4,
        HALT = 3'd5,
        DONE = 3'd6
    } phase_e;

    localparam int unsigned M1   = (FWD_T > REV_T) ? FWD_T : REV_T;
    localparam int unsigned M2   = (PAUSE_T > ALARM_T) ? PAUSE_T : ALARM_T;
    localparam int unsigned TMAX = (M1 > M2) ? M1 : M2;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    localparam logic [CNT_W:0]   STEP_W = (CNT_W+1)'(ADD_STEP);
    localparam logic [CNT_W:0]   MAX_W  = (CNT_W+1)'(MAX_TIME);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic [TW-1:0]    ONE_T  = TW'(1);

    phase_e           ph_q, ph_d;
    phase_e           sv_q, sv_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic             mode_q, mode_d;
    logic             zheng_q, fan_q, alarm_q, ledstop_q;

    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] cnt_add;
    logic [CNT_W-1:0] cnt_dec;
    logic [TW-1:0]    tmr_inc;
    logic [TW-1:0]    plen;
    phase_e           ph_nxt;

    always_comb begin
        sum     = {1'b0, cnt_q} + STEP_W;
        cnt_add = (sum > MAX_W) ? MAX_W[CNT_W-1:0] : sum[CNT_W-1:0];
        cnt_dec = cnt_q - ONE_C;
        tmr_inc = tmr_q + ONE_T;

        plen   = TW'(PAUSE_T);
        ph_nxt = FWD;
        case (ph_q)
            FWD: begin
                plen   = TW'(FWD_T);
                ph_nxt = P1;
            end
            P1: begin
                plen   = TW'(PAUSE_T);
                ph_nxt = mode_q ? FWD : REV;
            end
            REV: begin
                plen   = TW'(REV_T);
                ph_nxt = P2;
            end
            P2: begin
                plen   = TW'(PAUSE_T);
                ph_nxt = FWD;
            end
            default: begin
                plen   = TW'(PAUSE_T);
                ph_nxt = FWD;
            end
        endcase
    end

    always_comb begin
        ph_d   = ph_q;
        sv_d   = sv_q;
        cnt_d  = cnt_q;
        tmr_d  = tmr_q;
        mode_d = mode_q;
        case (ph_q)
            IDLE: begin
                // add lands first so add+start together can launch a wash
                if (bus.add) cnt_d = cnt_add;
                if (bus.start && (cnt_d != '0)) begin
                    ph_d   = FWD;
                    tmr_d  = '0;
                    mode_d = bus.mode;
                end
            end
            FWD, P1, REV, P2: begin
                if (bus.emergency) begin
                    ph_d = HALT;
                    sv_d = ph_q;
                end else if (bus.tick) begin
                    cnt_d = cnt_dec;
                    if (cnt_dec == '0) begin
                        ph_d  = DONE;
                        tmr_d = '0;
                    end else if (tmr_inc == plen) begin
                        ph_d  = ph_nxt;
                        tmr_d = '0;
                    end else begin
                        tmr_d = tmr_inc;
                    end
                end
            end
            HALT: begin
                if (bus.start) ph_d = sv_q;
            end
            DONE: begin
                cnt_d = '0;
                if (bus.tick) begin
                    if (tmr_inc == TW'(ALARM_T)) begin
                        ph_d  = IDLE;
                        tmr_d = '0;
                    end else begin
                        tmr_d = tmr_inc;
                    end
                end
            end
            default: begin
                ph_d  = IDLE;
                cnt_d = '0;
                tmr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph_q      <= IDLE;
            sv_q      <= IDLE;
            cnt_q     <= '0;
            tmr_q     <= '0;
            mode_q    <= 1'b0;
            zheng_q   <= 1'b0;
            fan_q     <= 1'b0;
            alarm_q   <= 1'b0;
            ledstop_q <= 1'b1;
        end else begin
            ph_q      <= ph_d;
            sv_q      <= sv_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            mode_q    <= mode_d;
            zheng_q   <= (ph_d == FWD);
            fan_q     <= (ph_d == REV);
            alarm_q   <= (ph_d == DONE);
            ledstop_q <= (ph_d != FWD) && (ph_d != REV);
        end
    end

    assign bus.zheng    = zheng_q;
    assign bus.fan      = fan_q;
    assign bus.ledzheng = zheng_q;
    assign bus.ledfan   = fan_q;
    assign bus.ledstop  = ledstop_q;
    assign bus.alarm    = alarm_q;
    assign bus.count    = cnt_q;
    assign bus.phase    = ph_q;

endmodule

// File: tb/tb_washer_ctrl_param.sv
// Directed bench for washer_ctrl_param with short phase lengths.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_washer_ctrl_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vec = 0;
    int   err = 0;

    always #5 clk = ~clk;

    washer_ctrl_param_if #(.CNT_W(6)) bus ();

    washer_ctrl_param #(
        .CNT_W(6), .MAX_TIME(10), .ADD_STEP(1),
        .FWD_T(3), .REV_T(3), .PAUSE_T(1), .ALARM_T(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic a, input logic s,
                         input logic e, input logic t);
        bus.add = a;
        bus.start = s;
        bus.emergency = e;
        bus.tick = t;
        @(negedge clk);
        bus.add = 1'b0;
        bus.start = 1'b0;
        bus.emergency = 1'b0;
        bus.tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic adds(input int n);
        for (int i = 0; i < n; i++) pulse(1, 0, 0, 0);
    endtask

    task automatic tick();
        pulse(0, 0, 0, 1);
    endtask

    task automatic chk_motor(input string tag, input int ph);
        chk({tag, "_phase"}, 32'(bus.phase), 32'(ph));
        chk({tag, "_zheng"}, 32'(bus.zheng), 32'(ph == 1));
        chk({tag, "_fan"}, 32'(bus.fan), 32'(ph == 3));
        chk({tag, "_ledstop"}, 32'(bus.ledstop), 32'(ph != 1 && ph != 3));
    endtask

    int ph2[8] = '{1, 1, 2, 3, 3, 3, 4, 6};
    int ph3[8] = '{1, 1, 2, 1, 1, 1, 2, 6};

    initial begin
        bus.tick = 1'b0;
        bus.add = 1'b0;
        bus.start = 1'b0;
        bus.emergency = 1'b0;
        bus.mode = 1'b0;

        // reset state
        do_reset();
        chk("rst_phase", 32'(bus.phase), 0);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_ledstop", 32'(bus.ledstop), 1);
        chk("rst_alarm", 32'(bus.alarm), 0);
        chk("rst_zheng", 32'(bus.zheng), 0);

        // saturation at MAX_TIME
        adds(12);
        chk("sat_count", 32'(bus.count), 10);
        chk("sat_phase", 32'(bus.phase), 0);
        chk("sat_ledstop", 32'(bus.ledstop), 1);
        pulse(0, 0, 1, 1);
        chk("idle_emer_tick", 32'(bus.phase), 0);
        chk("idle_emer_cnt", 32'(bus.count), 10);

        // bidirectional wash of 8
        do_reset();
        adds(8);
        bus.mode = 1'b0;
        pulse(0, 1, 0, 0);
        chk_motor("t2_start", 1);
        chk("t2_start_cnt", 32'(bus.count), 8);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_motor($sformatf("t2_tk%0d", i + 1), ph2[i]);
            chk($sformatf("t2_cnt%0d", i + 1), 32'(bus.count), 32'(7 - i));
            if (i == 0) begin
                pulse(1, 1, 0, 0);
                chk("t2_run_add_ign", 32'(bus.count), 7);
                chk("t2_run_ph_ign", 32'(bus.phase), 1);
            end
        end
        chk("t2_alarm_on", 32'(bus.alarm), 1);
        pulse(1, 1, 1, 0);
        chk("t2_done_ign_ph", 32'(bus.phase), 6);
        chk("t2_done_ign_cnt", 32'(bus.count), 0);
        tick();
        chk("t2_alarm_hold", 32'(bus.alarm), 1);
        chk("t2_done_hold", 32'(bus.phase), 6);
        tick();
        chk("t2_alarm_off", 32'(bus.alarm), 0);
        chk("t2_idle", 32'(bus.phase), 0);

        // forward-only wash of 8; mode only matters at start
        do_reset();
        adds(8);
        bus.mode = 1'b1;
        pulse(0, 1, 0, 0);
        bus.mode = 1'b0;
        chk_motor("t3_start", 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_motor($sformatf("t3_tk%0d", i + 1), ph3[i]);
        end
        chk("t3_alarm", 32'(bus.alarm), 1);
        tick();
        tick();
        chk("t3_idle", 32'(bus.phase), 0);

        // emergency hold and resume
        do_reset();
        adds(6);
        pulse(0, 1, 0, 0);
        tick();
        tick();
        chk("t4_pre_cnt", 32'(bus.count), 4);
        pulse(0, 0, 1, 0);
        chk_motor("t4_halt", 5);
        tick();
        tick();
        pulse(1, 0, 1, 0);
        chk("t4_halt_cnt", 32'(bus.count), 4);
        chk("t4_halt_ph", 32'(bus.phase), 5);
        pulse(0, 1, 0, 0);
        chk_motor("t4_resume", 1);
        chk("t4_resume_cnt", 32'(bus.count), 4);
        tick();
        chk_motor("t4_p1", 2);
        chk("t4_p1_cnt", 32'(bus.count), 3);

        // emergency beats a same-cycle tick
        pulse(0, 0, 1, 1);
        chk("t5_emtk_ph", 32'(bus.phase), 5);
        chk("t5_emtk_cnt", 32'(bus.count), 3);
        pulse(0, 1, 0, 0);
        chk("t5_resume_p1", 32'(bus.phase), 2);
        tick();
        chk_motor("t5_rev", 3);
        chk("t5_rev_cnt", 32'(bus.count), 2);

        // start with count zero, then add+start together
        do_reset();
        pulse(0, 1, 0, 0);
        chk("t5_zero_start", 32'(bus.phase), 0);
        pulse(1, 1, 0, 0);
        chk_motor("t5_addstart", 1);
        chk("t5_addstart_cnt", 32'(bus.count), 1);
        tick();
        chk("t5_one_done", 32'(bus.phase), 6);
        chk("t5_one_cnt", 32'(bus.count), 0);
        chk("t5_one_alarm", 32'(bus.alarm), 1);

        // async reset mid-REV
        do_reset();
        adds(8);
        pulse(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) tick();
        chk_motor("t6_rev", 3);
        chk("t6_rev_cnt", 32'(bus.count), 4);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_ph", 32'(bus.phase), 0);
        chk("t6_rst_cnt", 32'(bus.count), 0);
        chk("t6_rst_fan", 32'(bus.fan), 0);
        chk("t6_rst_alarm", 32'(bus.alarm), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
